// File: rtl/wb_regfile.sv
// wb_regfile: 31x32 GPR file plus HI/LO with two combinational read ports and a commit counter.
// WB_BYPASS_EN: when defined, same-cycle writeback data is forwarded to the read ports and HI/LO outputs.
`default_nettype none

module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_wd,
  input  logic        wb_wreg,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        wb_enhilo,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] commit_cnt
);

  logic [31:0] gpr_q [1:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        gpr_we;
  logic        commit;

  assign gpr_we = wb_wreg && (wb_wd != 5'd0);
  assign commit = gpr_we || wb_enhilo;

  always_comb begin
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      cnt_q <= 32'd0;
    end else begin
      if (gpr_we) begin
        gpr_q[wb_wd] <= wb_wdata;
      end
      if (wb_enhilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
      cnt_q <= cnt_d;
    end
  end

  // Priority: disabled port, index 0, reset, then (optional) forwarding, then storage.
  function automatic logic [31:0] read_port(input logic re, input logic [4:0] ra);
    logic [31:0] v;
    v = 32'd0;
    if (re && (ra != 5'd0) && !rst) begin
`ifdef WB_BYPASS_EN
      if (wb_wreg && (wb_wd == ra)) begin
        v = wb_wdata;
      end else begin
        v = gpr_q[ra];
      end
`else
      v = gpr_q[ra];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    if (!rst) begin
`ifdef WB_BYPASS_EN
      hi_o = wb_enhilo ? wb_hi : hi_q;
      lo_o = wb_enhilo ? wb_lo : lo_q;
`else
      hi_o = hi_q;
      lo_o = lo_q;
`endif
    end
  end

  assign commit_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// Scoreboarded random/directed bench for wb_regfile against an architectural register-file model.
`default_nettype none

module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_enhilo;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] commit_cnt;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_enhilo(wb_enhilo),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  bit done = 0;

  // Architectural state of the reference model
  logic [31:0] m_gpr [0:31];
  logic [31:0] m_hi, m_lo, m_cnt;

  function automatic logic [31:0] m_read(input logic re, input logic [4:0] ra);
    if (!re || ra == 5'd0 || rst) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_wreg && wb_wd == ra) return wb_wdata;
`endif
    return m_gpr[ra];
  endfunction

  task automatic cycle(input logic r, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic enhilo, input logic [31:0] h, input logic [31:0] l,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                       input bit chk);
    exp_t e;
    @(negedge clk);
    rst = r; wb_wd = wd; wb_wreg = wreg; wb_wdata = wdata;
    wb_enhilo = enhilo; wb_hi = h; wb_lo = l;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    e.rd1 = m_read(e1, a1);
    e.rd2 = m_read(e2, a2);
    if (r) begin
      e.hi = 32'd0; e.lo = 32'd0;
    end else begin
`ifdef WB_BYPASS_EN
      e.hi = enhilo ? h : m_hi;
      e.lo = enhilo ? l : m_lo;
`else
      e.hi = m_hi; e.lo = m_lo;
`endif
    end
    e.cnt = m_cnt;
    if (chk) q.push_back(e);
    // State the DUT should hold after the coming rising edge
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_cnt = 32'd0;
    end else begin
      if (wreg && wd != 5'd0) m_gpr[wd] = wdata;
      if (enhilo) begin m_hi = h; m_lo = l; end
      if ((wreg && wd != 5'd0) || enhilo) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples combinational outputs just before each rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata1", rdata1, e.rd1);
        chk("rdata2", rdata2, e.rd2);
        chk("hi_o", hi_o, e.hi);
        chk("lo_o", lo_o, e.lo);
        chk("commit_cnt", commit_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wd, a1, a2;
    rst = 1'b1; wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0; wb_enhilo = 1'b0;
    wb_hi = '0; wb_lo = '0; re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_hi = '0; m_lo = '0; m_cnt = '0;

    // Reset for one cycle, then read reg 5
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1);
    // Write reg 7, read it on both ports
    cycle(0, 7, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 1);
    // Write to reg 0 is dropped and not counted
    cycle(0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    // Same-cycle write/read of reg 3
    cycle(0, 3, 1, 32'h00000011, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 3, 1, 32'hA5A5A5A5, 0, 0, 0, 1, 3, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    // Combined HI/LO and GPR write counts once
    cycle(0, 9, 1, 32'h99990009, 1, 32'h1, 32'h2, 1, 9, 1, 9, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1);
    // Counter wrap from preloaded all-ones
    @(posedge clk);
    #1;
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 12, 1, 32'h0000C0DE, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 4, 1, 32'h0000CAFE, 0, 0, 0, 1, 12, 0, 0, 1);
    cycle(1, 4, 1, 32'h0000BEEF, 1, 32'h7, 32'h8, 1, 4, 1, 12, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 12, 1);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      wd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 24) == 0), wd, 1'($urandom), $urandom,
            1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2, 1);
    end

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
